// File: rtl/btn_debounce.sv
// Button/switch debouncer: metastability synchronizer, stability counter and
// 4-state qualification FSM, with a registered level and rise/fall pulses.
module btn_debounce #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic        ACTIVE_LOW    = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise_pulse,
    output logic o_fall_pulse
);

    localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit               DIRECT   = (STABLE_CYCLES == 1);

    typedef enum logic [1:0] {
        S_LOW,
        S_WAIT_HIGH,
        S_HIGH,
        S_WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_d;

    // Reset preloads the "not pressed" raw level so no false press follows reset.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    // NOTE: defaults first so every path assigns state_d/cnt_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_LOW: begin
                if (s) begin
                    if (DIRECT) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (!s) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_HIGH: begin
                if (!s) begin
                    if (DIRECT) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            S_WAIT_LOW: begin
                if (s) begin
                    state_d = S_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // The debounced level is the "high side" of the FSM, registered once more.
    assign level_d = (state_q == S_HIGH) || (state_q == S_WAIT_LOW);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_LOW;
            cnt_q        <= '0;
            o_level      <= 1'b0;
            o_rise_pulse <= 1'b0;
            o_fall_pulse <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            o_level      <= level_d;
            o_rise_pulse <= level_d & ~o_level;
            o_fall_pulse <= ~level_d & o_level;
        end
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: a window-based reference model checked every cycle on two
// configurations, plus directed scenarios with literal cycle-exact expectations.
module tb_btn_debounce;

    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst;
    logic btn_a, btn_b;
    logic lvl_a, rise_a, fall_a;
    logic lvl_b, rise_b, fall_b;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    btn_debounce #(.STABLE_CYCLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1'b0)) u_a (
        .i_clk(clk), .i_rst(rst), .i_btn(btn_a),
        .o_level(lvl_a), .o_rise_pulse(rise_a), .o_fall_pulse(fall_a)
    );

    btn_debounce #(.STABLE_CYCLES(1), .SYNC_STAGES(2), .ACTIVE_LOW(1'b1)) u_b (
        .i_clk(clk), .i_rst(rst), .i_btn(btn_b),
        .o_level(lvl_b), .o_rise_pulse(rise_b), .o_fall_pulse(fall_b)
    );

    // Model: the level flips at edge k when the "pressed" samples taken at edges
    // k-SYNC-STABLE .. k-SYNC-1 all disagree with the current level.
    typedef struct packed {
        logic [7:0] hist;
        logic       lvl;
        logic       rise;
        logic       fall;
    } model_t;

    model_t ma, mb;
    logic   model_on = 1'b0;

    function automatic model_t model_next(model_t m, logic r, logic pressed, int stable);
        model_t n;
        logic   flip;
        n = '0;
        if (!r) begin
            n.hist = {m.hist[6:0], pressed};
            flip   = 1'b1;
            for (int i = SYNC + 1; i <= SYNC + stable; i++) begin
                if (n.hist[i] == m.lvl) flip = 1'b0;
            end
            n.rise = flip & ~m.lvl;
            n.fall = flip & m.lvl;
            n.lvl  = m.lvl ^ flip;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= model_next(ma, rst, btn_a, 4);
        mb <= model_next(mb, rst, ~btn_b, 1);
        if (rst) model_on <= 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("model level_a", lvl_a,  ma.lvl);
            check("model rise_a",  rise_a, ma.rise);
            check("model fall_a",  fall_a, ma.fall);
            check("model level_b", lvl_b,  mb.lvl);
            check("model rise_b",  rise_b, mb.rise);
            check("model fall_b",  fall_b, mb.fall);
        end
    end

    task automatic tick(input logic ba, input logic bb);
        btn_a = ba;
        btn_b = bb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] bounce;
        int         n_rise;

        rst   = 1'b1;
        btn_a = 1'b0;
        btn_b = 1'b1;
        repeat (3) tick(1'b0, 1'b1);
        check("reset level_a", lvl_a,  0);
        check("reset rise_a",  rise_a, 0);
        check("reset fall_a",  fall_a, 0);
        check("reset level_b", lvl_b,  0);
        rst = 1'b0;
        repeat (4) tick(1'b0, 1'b1);

        // Clean press: the first tick is edge 0.
        for (int e = 0; e <= 7; e++) begin
            tick(1'b1, 1'b1);
            check("press level", lvl_a,  32'(e >= 6));
            check("press rise",  rise_a, 32'(e == 6));
            check("press fall",  fall_a, 0);
        end

        // Release after press.
        for (int e = 0; e <= 7; e++) begin
            tick(1'b0, 1'b1);
            check("release level", lvl_a,  32'(e < 6));
            check("release fall",  fall_a, 32'(e == 6));
            check("release rise",  rise_a, 0);
        end
        repeat (3) tick(1'b0, 1'b1);

        // Glitch: three high samples never qualify.
        for (int e = 0; e <= 11; e++) begin
            tick(1'(e < 3), 1'b1);
            check("glitch outputs", lvl_a | rise_a | fall_a, 0);
        end

        // Bounce train 1,0,1,1,0,1 then steady high; final rising sample is index 5.
        bounce = 6'b101101;
        n_rise = 0;
        for (int e = 0; e <= 14; e++) begin
            tick((e < 6) ? bounce[e] : 1'b1, 1'b1);
            if (rise_a) n_rise++;
            check("bounce rise",  rise_a, 32'(e == 11));
            check("bounce level", lvl_a,  32'(e >= 11));
        end
        check("bounce rise count", n_rise, 1);
        repeat (10) tick(1'b0, 1'b1);
        check("bounce released", lvl_a, 0);

        // Reset while qualifying (cnt=2 after edge 3), then a full fresh latency.
        for (int e = 0; e <= 3; e++) tick(1'b1, 1'b1);
        rst = 1'b1;
        tick(1'b1, 1'b1);
        check("midreset level", lvl_a,  0);
        check("midreset rise",  rise_a, 0);
        check("midreset fall",  fall_a, 0);
        rst = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            tick(1'b1, 1'b1);
            check("post-reset level", lvl_a,  32'(e >= 6));
            check("post-reset rise",  rise_a, 32'(e == 6));
        end

        // Reset while pressed: level drops, then re-qualifies with one rise pulse.
        rst = 1'b1;
        tick(1'b1, 1'b1);
        check("held reset level", lvl_a,  0);
        check("held reset fall",  fall_a, 0);
        rst = 1'b0;
        for (int e = 0; e <= 7; e++) begin
            tick(1'b1, 1'b1);
            check("held re-rise level", lvl_a,  32'(e >= 6));
            check("held re-rise rise",  rise_a, 32'(e == 6));
            check("held re-rise fall",  fall_a, 0);
        end

        // Active-low, single-cycle qualification.
        check("active-low idle level", lvl_b, 0);
        for (int e = 0; e <= 4; e++) begin
            tick(1'b1, 1'b0);
            check("active-low press level", lvl_b,  32'(e >= 3));
            check("active-low press rise",  rise_b, 32'(e == 3));
        end
        for (int e = 0; e <= 4; e++) begin
            tick(1'b1, 1'b1);
            check("active-low release level", lvl_b,  32'(e < 3));
            check("active-low release fall",  fall_b, 32'(e == 3));
        end
        repeat (2) tick(1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
